fir_hls_acc_round_sat: RTL and testbench



---
 rtl/fir_hls_pkg.sv | 9 +
 rtl/fir_hls_round_sat.sv | 27 ++
 rtl/fir_hls_acc_round_sat.sv | 66 ++++++
 tb/tb_fir_hls_acc_round_sat.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fir_hls_pkg.sv
// fir_hls_pkg: FIR datapath widths shared by multiplier, coefficient ROM and output stages
package fir_hls_pkg;
  localparam int DEF_PROD_WIDTH = 28;
  localparam int DEF_OUT_WIDTH = 16;
  localparam int DEF_FRAC_SHIFT = 11;
  function automatic int min_acc_width(input int prod_width, input int num_taps);
    return prod_width + $clog2(num_taps);
  endfunction
endpackage

// File: rtl/fir_hls_round_sat.sv
// fir_hls_round_sat: round-half-up by FRAC_SHIFT then clamp to a signed OUT_WIDTH sample
module fir_hls_round_sat
  import fir_hls_pkg::*;
#(
  parameter int ACC_WIDTH = 36,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0] i_sum,
  output logic signed [OUT_WIDTH-1:0] o_y,
  output logic                        o_sat
);
  localparam int W1 = ACC_WIDTH + 1;
  localparam logic signed [W1-1:0] HALF = W1'(1) <<< (FRAC_SHIFT - 1);
  localparam logic signed [W1-1:0] W_MAX = W1'((1 <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [W1-1:0] W_MIN = -W_MAX - W1'(1);
  logic signed [W1-1:0] w_rnd, w_r;
  logic w_hi, w_lo;
  assign w_rnd = W1'(i_sum) + HALF;
  assign w_r = w_rnd >>> FRAC_SHIFT;
  always_comb begin
    w_hi = w_r > W_MAX;
    w_lo = w_r < W_MIN;
    o_sat = w_hi || w_lo;
    o_y = w_hi ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : w_lo ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : w_r[OUT_WIDTH-1:0];
  end
endmodule

// File: rtl/fir_hls_acc_round_sat.sv
// fir_hls_acc_round_sat: accumulate NUM_TAPS products per frame, emit rounded/saturated sample on a valid/ready stream
module fir_hls_acc_round_sat
  import fir_hls_pkg::*;
#(
  parameter int PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int ACC_WIDTH = 36,
  parameter int NUM_TAPS = 64,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic signed [PROD_WIDTH-1:0] prod_tdata,
  input  logic                         prod_tvalid,
  output logic                         prod_tready,
  input  logic                         prod_tlast,
  output logic signed [OUT_WIDTH-1:0]  y_tdata,
  output logic                         y_tvalid,
  input  logic                         y_tready,
  output logic                         sat_flag,
  output logic                         frame_err
);
  localparam int CW = $clog2(NUM_TAPS);
  localparam logic [CW-1:0] LAST = CW'(NUM_TAPS - 1);
  logic signed [ACC_WIDTH-1:0] r_acc, w_sum;
  logic [CW-1:0] r_tap_cnt;
  logic signed [OUT_WIDTH-1:0] w_y;
  logic w_last, w_accept, w_sat;
  assign w_last = r_tap_cnt == LAST;
  // only the frame-closing tap needs a free output register
  assign prod_tready = !(w_last && y_tvalid && !y_tready);
  assign w_accept = prod_tvalid && prod_tready;
  assign w_sum = r_acc + ACC_WIDTH'(prod_tdata);
  fir_hls_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_SHIFT(FRAC_SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .i_sum(w_sum),
    .o_y  (w_y),
    .o_sat(w_sat)
  );
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_acc <= '0;
      r_tap_cnt <= '0;
      y_tdata <= '0;
      y_tvalid <= 1'b0;
      sat_flag <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= w_last ? '0 : w_sum;
        r_tap_cnt <= w_last ? '0 : r_tap_cnt + CW'(1);
        if (prod_tlast != w_last) frame_err <= 1'b1;
      end
      if (w_accept && w_last) begin
        y_tdata <= w_y;
        y_tvalid <= 1'b1;
        sat_flag <= sat_flag | w_sat;
      end else if (y_tready) begin
        y_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fir_hls_acc_round_sat.sv
// tb_fir_hls_acc_round_sat: directed vectors for the 4-tap accumulate/round/saturate stage
module tb_fir_hls_acc_round_sat;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic signed [27:0] prod_tdata = '0;
  logic prod_tvalid = 1'b0;
  logic prod_tready;
  logic prod_tlast = 1'b0;
  logic signed [15:0] y_tdata;
  logic y_tvalid;
  logic y_tready = 1'b1;
  logic sat_flag;
  logic frame_err;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic signed [27:0] p [4];
    int y;
    logic sat;
  } vec_t;
  vec_t tbl [9];

  fir_hls_acc_round_sat #(.NUM_TAPS(4)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .prod_tdata (prod_tdata),
    .prod_tvalid(prod_tvalid),
    .prod_tready(prod_tready),
    .prod_tlast (prod_tlast),
    .y_tdata    (y_tdata),
    .y_tvalid   (y_tvalid),
    .y_tready   (y_tready),
    .sat_flag   (sat_flag),
    .frame_err  (frame_err)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int a, input int b, input int c, input int d, input int y, input logic s);
    vec_t v;
    v.p[0] = 28'(a);
    v.p[1] = 28'(b);
    v.p[2] = 28'(c);
    v.p[3] = 28'(d);
    v.y = y;
    v.sat = s;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_tap(input logic signed [27:0] d, input logic l);
    int t = 0;
    logic ok;
    prod_tdata = d;
    prod_tlast = l;
    prod_tvalid = 1'b1;
    do begin
      @(negedge ap_clk);
      ok = prod_tready;
      @(posedge ap_clk);
      #1;
      t++;
    end while (!ok && t < 50);
    prod_tvalid = 1'b0;
    prod_tlast = 1'b0;
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL tap_accept: timeout waiting for prod_tready");
    end
  endtask

  task automatic send_frame(input int v);
    for (int k = 0; k < 4; k++) send_tap(28'(v), k == 3);
  endtask

  initial begin
    tbl[0] = mk(2048, 2048, 2048, 2048, 4, 1'b0);
    tbl[1] = mk(-1024, 0, 0, 0, 0, 1'b0);
    tbl[2] = mk(-1025, 0, 0, 0, -1, 1'b0);
    tbl[3] = mk(1000, 2000, -500, 3, 1, 1'b0);
    tbl[4] = mk(67107839, 0, 0, 0, 32767, 1'b0);
    tbl[5] = mk(-67109888, 0, 0, 0, -32768, 1'b0);
    tbl[6] = mk(67107840, 0, 0, 0, 32767, 1'b1);
    tbl[7] = mk(1 << 26, 1 << 26, 1 << 26, 1 << 26, 32767, 1'b1);
    tbl[8] = mk(-(1 << 26), -(1 << 26), -(1 << 26), -(1 << 26), -32768, 1'b1);

    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_y_tdata", int'(y_tdata), 0);
    check("rst_y_tvalid", int'(y_tvalid), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_prod_tready", int'(prod_tready), 1);
    ap_rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 4; k++) send_tap(tbl[i].p[k], k == 3);
      check($sformatf("vec%0d_y", i), int'(y_tdata), tbl[i].y);
      check($sformatf("vec%0d_valid", i), int'(y_tvalid), 1);
      check($sformatf("vec%0d_sat", i), int'(sat_flag), int'(tbl[i].sat));
      check($sformatf("vec%0d_ferr", i), int'(frame_err), 0);
      @(posedge ap_clk);
      #1;
      check($sformatf("vec%0d_drain", i), int'(y_tvalid), 0);
    end

    send_tap(28'(2048), 1'b0);
    send_tap(28'(2048), 1'b0);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    check("midrst_valid", int'(y_tvalid), 0);
    check("midrst_sat", int'(sat_flag), 0);
    check("midrst_ferr", int'(frame_err), 0);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    check("postrst_valid", int'(y_tvalid), 0);
    check("postrst_sat", int'(sat_flag), 0);
    send_frame(2048);
    check("postrst_y", int'(y_tdata), 4);
    check("postrst_frame_valid", int'(y_tvalid), 1);
    @(posedge ap_clk);
    #1;

    y_tready = 1'b0;
    send_frame(2048);
    check("bp_f1_y", int'(y_tdata), 4);
    check("bp_f1_valid", int'(y_tvalid), 1);
    for (int k = 0; k < 3; k++) send_tap(28'(4096), 1'b0);
    prod_tdata = 28'(4096);
    prod_tlast = 1'b1;
    prod_tvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      check($sformatf("bp_stall%0d_ready", c), int'(prod_tready), 0);
      check($sformatf("bp_stall%0d_y", c), int'(y_tdata), 4);
      check($sformatf("bp_stall%0d_valid", c), int'(y_tvalid), 1);
    end
    @(posedge ap_clk);
    #1;
    y_tready = 1'b1;
    @(negedge ap_clk);
    check("bp_release_ready", int'(prod_tready), 1);
    @(posedge ap_clk);
    #1;
    prod_tvalid = 1'b0;
    prod_tlast = 1'b0;
    check("bp_f2_y", int'(y_tdata), 8);
    check("bp_f2_valid", int'(y_tvalid), 1);
    @(posedge ap_clk);
    #1;
    check("bp_f2_drain", int'(y_tvalid), 0);
    check("bp_ferr", int'(frame_err), 0);

    send_tap(28'(2048), 1'b0);
    send_tap(28'(2048), 1'b1);
    check("ferr_early_last", int'(frame_err), 1);
    check("ferr_no_output_yet", int'(y_tvalid), 0);
    send_tap(28'(2048), 1'b0);
    send_tap(28'(2048), 1'b1);
    check("ferr_frame_y", int'(y_tdata), 4);
    check("ferr_frame_valid", int'(y_tvalid), 1);
    check("ferr_sticky", int'(frame_err), 1);
    check("ferr_sat", int'(sat_flag), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
